// File: rtl/coreapb3_iaddr_seq_if.sv
// rtl/coreapb3_iaddr_seq_if.sv - APB3 bus bundle between the sequencer (master) and the target slave
interface coreapb3_iaddr_seq_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/coreapb3_iaddr_seq.sv
// rtl/coreapb3_iaddr_seq.sv - two-requester APB3 master reaching a wide target space through a page register and data window
module coreapb3_iaddr_seq #(
    parameter logic [31:0] IADDR_OFFSET = 32'h0000_0000,
    parameter logic [31:0] WIN_BASE     = 32'h0000_1000,
    parameter int          WIN_BITS     = 12
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA,
    output logic        ERR,
    coreapb3_iaddr_seq_if.master apb
);
    localparam logic [31:0] OFF_MASK = (32'h1 << WIN_BITS) - 32'h1;

    typedef enum logic [2:0] {
        IDLE, I_SETUP, I_ACCESS, D_SETUP, D_ACCESS, DONE
    } state_t;

    state_t      state;
    logic        prio;
    logic        lat_id;
    logic [31:0] lat_addr;
    logic        lat_wr;
    logic [31:0] lat_wdata;
    logic [31:0] cache_page;
    logic        cache_valid;

    logic        gnt_any;
    logic        gnt_id;
    logic [31:0] g_addr;
    logic        g_wr;
    logic [31:0] g_wdata;
    logic [31:0] g_page;
    logic [31:0] g_win;
    logic        g_hit;
    logic [31:0] lat_page;
    logic [31:0] lat_win;

    // prio names the requester that wins a tie; it flips to the other one after every grant
    always_comb begin
        gnt_any  = REQ0 | REQ1;
        gnt_id   = (REQ0 && REQ1) ? prio : REQ1;
        g_addr   = gnt_id ? ADDR1  : ADDR0;
        g_wr     = gnt_id ? WR1    : WR0;
        g_wdata  = gnt_id ? WDATA1 : WDATA0;
        g_page   = g_addr & ~OFF_MASK;
        g_win    = WIN_BASE | (g_addr & OFF_MASK);
        g_hit    = cache_valid && (cache_page == g_page);
        lat_page = lat_addr & ~OFF_MASK;
        lat_win  = WIN_BASE | (lat_addr & OFF_MASK);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            prio        <= 1'b0;
            lat_id      <= 1'b0;
            lat_addr    <= 32'h0;
            lat_wr      <= 1'b0;
            lat_wdata   <= 32'h0;
            cache_page  <= 32'h0;
            cache_valid <= 1'b0;
            ACK0        <= 1'b0;
            ACK1        <= 1'b0;
            RDATA       <= 32'h0;
            ERR         <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= 32'h0;
            apb.PWDATA  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    ACK0        <= 1'b0;
                    ACK1        <= 1'b0;
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    if (gnt_any) begin
                        lat_id    <= gnt_id;
                        lat_addr  <= g_addr;
                        lat_wr    <= g_wr;
                        lat_wdata <= g_wdata;
                        prio      <= ~gnt_id;
                        apb.PSEL  <= 1'b1;
                        if (g_hit) begin
                            state      <= D_SETUP;
                            apb.PWRITE <= g_wr;
                            apb.PADDR  <= g_win;
                            apb.PWDATA <= g_wr ? g_wdata : 32'h0;
                        end else begin
                            state      <= I_SETUP;
                            apb.PWRITE <= 1'b1;
                            apb.PADDR  <= IADDR_OFFSET;
                            apb.PWDATA <= g_page;
                        end
                    end
                end
                I_SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= I_ACCESS;
                end
                I_ACCESS: begin
                    if (apb.PREADY) begin
                        if (apb.PSLVERR) begin
                            // the page register may hold anything now, so force a reload next time
                            cache_valid <= 1'b0;
                            apb.PSEL    <= 1'b0;
                            apb.PENABLE <= 1'b0;
                            ACK0        <= ~lat_id;
                            ACK1        <= lat_id;
                            RDATA       <= 32'h0;
                            ERR         <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cache_page  <= lat_page;
                            cache_valid <= 1'b1;
                            apb.PENABLE <= 1'b0;
                            apb.PWRITE  <= lat_wr;
                            apb.PADDR   <= lat_win;
                            apb.PWDATA  <= lat_wr ? lat_wdata : 32'h0;
                            state       <= D_SETUP;
                        end
                    end
                end
                D_SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= D_ACCESS;
                end
                D_ACCESS: begin
                    if (apb.PREADY) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        ACK0        <= ~lat_id;
                        ACK1        <= lat_id;
                        RDATA       <= lat_wr ? 32'h0 : apb.PRDATA;
                        ERR         <= apb.PSLVERR;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    ACK0        <= 1'b0;
                    ACK1        <= 1'b0;
                    RDATA       <= 32'h0;
                    ERR         <= 1'b0;
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
